mvu_dma_ctrl: RTL and testbench

//  Transfer sequencer behind the MVU DMA register block. On a start pulse it latches

---
 rtl/mvu_dma_ctrl_if.sv | 32 +++
 rtl/mvu_dma_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mvu_dma_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mvu_dma_ctrl_if.sv
// Bus bundle between the MVU DMA sequencer and its ICB read port plus MVU RAM write port.
// The master modport is the DMA side; the slave modport is the bus/memory side.
interface mvu_dma_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MVU_ADDR_W = 15
) ();
  logic                  m_icb_cmd_valid;
  logic                  m_icb_cmd_ready;
  logic [ADDR_W-1:0]     m_icb_cmd_addr;
  logic                  m_icb_cmd_read;
  logic                  m_icb_rsp_valid;
  logic                  m_icb_rsp_ready;
  logic                  m_icb_rsp_err;
  logic [DATA_W-1:0]     m_icb_rsp_rdata;
  logic                  mvu_wr_data_en;
  logic                  mvu_wr_weight_en;
  logic [MVU_ADDR_W-1:0] mvu_wr_addr;
  logic [DATA_W-1:0]     mvu_wr_data;

  modport master (
    output m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_read, m_icb_rsp_ready,
    output mvu_wr_data_en, mvu_wr_weight_en, mvu_wr_addr, mvu_wr_data,
    input  m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, m_icb_rsp_rdata
  );

  modport slave (
    input  m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_read, m_icb_rsp_ready,
    input  mvu_wr_data_en, mvu_wr_weight_en, mvu_wr_addr, mvu_wr_data,
    output m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, m_icb_rsp_rdata
  );
endinterface

// File: rtl/mvu_dma_ctrl.sv
// MVU DMA transfer sequencer: copies (size+1) words from DRAM over ICB into MVU data/weight RAM.
// Optional MVU_DMA_ABORT_ON_ERR_EN: a response error ends the transfer without writing that beat.
module mvu_dma_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int MVU_ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_src_addr_i,
  input  logic [31:0]       cfg_dst_addr_i,
  input  logic [LEN_W-1:0]  cfg_size_i,
  input  logic              cfg_role_i,
  input  logic              cfg_start_i,
  output logic [31:0]       status_o,
  output logic              dma_done_o,
  mvu_dma_ctrl_if.master    bus
);

  localparam logic [ADDR_W-1:0]     SRC_STRIDE = ADDR_W'(DATA_W / 8);
  localparam logic [MVU_ADDR_W-1:0] DST_ONE    = MVU_ADDR_W'(1);
  localparam logic [LEN_W:0]        CNT_ONE    = (LEN_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_W-1:0]     cur_src_q,  cur_src_d;
  logic [MVU_ADDR_W-1:0] cur_dst_q,  cur_dst_d;
  logic [LEN_W-1:0]      size_q,     size_d;
  logic                  role_q,     role_d;
  logic [DATA_W-1:0]     rdata_q,    rdata_d;
  logic [LEN_W:0]        beat_cnt_q, beat_cnt_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;
  logic                  unused_dst_hi_s;

  // Upper destination bits are outside the MVU RAM address space.
  assign unused_dst_hi_s = ^cfg_dst_addr_i[31:MVU_ADDR_W];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      size_q     <= '0;
      role_q     <= 1'b0;
      rdata_q    <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      size_q     <= size_d;
      role_q     <= role_d;
      rdata_q    <= rdata_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    size_d     = size_q;
    role_d     = role_q;
    rdata_d    = rdata_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          cur_src_d  = cfg_src_addr_i;
          cur_dst_d  = cfg_dst_addr_i[MVU_ADDR_W-1:0];
          size_d     = cfg_size_i;
          role_d     = cfg_role_i;
          beat_cnt_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_RD_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (bus.m_icb_cmd_ready) begin
          state_d = S_RD_WAIT;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (bus.m_icb_rsp_valid) begin
          rdata_d = bus.m_icb_rsp_rdata;
          if (bus.m_icb_rsp_err) begin
            err_d = 1'b1;
`ifdef MVU_DMA_ABORT_ON_ERR_EN
            state_d = S_DONE;
`else
            state_d = S_WR;
`endif
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_WR: begin
        beat_cnt_d = beat_cnt_q + CNT_ONE;
        // Count holds beats already written, so equality with size marks the last beat.
        if (beat_cnt_q == {1'b0, size_q}) begin
          state_d = S_DONE;
        end else begin
          cur_src_d = cur_src_q + SRC_STRIDE;
          cur_dst_d = cur_dst_q + DST_ONE;
          state_d   = S_RD_REQ;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    bus.m_icb_cmd_valid  = (state_q == S_RD_REQ);
    bus.m_icb_cmd_addr   = cur_src_q;
    bus.m_icb_cmd_read   = 1'b1;
    bus.m_icb_rsp_ready  = (state_q == S_RD_WAIT);
    bus.mvu_wr_data_en   = (state_q == S_WR) && !role_q;
    bus.mvu_wr_weight_en = (state_q == S_WR) && role_q;
    bus.mvu_wr_addr      = cur_dst_q;
    bus.mvu_wr_data      = rdata_q;
    dma_done_o           = (state_q == S_DONE);
    status_o             = {16'(beat_cnt_q), 13'd0, err_q, done_q, busy_q};
  end

endmodule

// File: tb/tb_mvu_dma_ctrl.sv
// Self-checking bench for mvu_dma_ctrl: ICB responder driven from tasks, MVU writes scoreboarded.
// Expected writes are queued when read data is returned and popped on each observed strobe.
module tb_mvu_dma_ctrl;

  localparam bit ABORT =
`ifdef MVU_DMA_ABORT_ON_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic        role;
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_src_addr = 32'd0;
  logic [31:0] cfg_dst_addr = 32'd0;
  logic [15:0] cfg_size     = 16'd0;
  logic        cfg_role     = 1'b0;
  logic        cfg_start    = 1'b0;
  logic [31:0] status;
  logic        dma_done;

  int  n_checks  = 0;
  int  n_errors  = 0;
  int  n_strobes = 0;
  wr_t exp_q[$];

  mvu_dma_ctrl_if #(.ADDR_W(32), .DATA_W(32), .MVU_ADDR_W(15)) u_if ();

  mvu_dma_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .MVU_ADDR_W(15)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_src_addr_i (cfg_src_addr),
    .cfg_dst_addr_i (cfg_dst_addr),
    .cfg_size_i     (cfg_size),
    .cfg_role_i     (cfg_role),
    .cfg_start_i    (cfg_start),
    .status_o       (status),
    .dma_done_o     (dma_done),
    .bus            (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (u_if.mvu_wr_data_en || u_if.mvu_wr_weight_en)) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        check_val("wr_unexpected", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_val("wr_strobe", {u_if.mvu_wr_weight_en, u_if.mvu_wr_data_en},
                  e.role ? 64'd2 : 64'd1);
        check_val("wr_addr", u_if.mvu_wr_addr, e.addr);
        check_val("wr_data", u_if.mvu_wr_data, e.data);
      end
    end
  end

  task automatic wait_cmd();
    for (int t = 0; t < 100 && !u_if.m_icb_cmd_valid; t++) @(negedge clk);
    check_val("cmd_valid", u_if.m_icb_cmd_valid, 64'd1);
  endtask

  task automatic do_xfer(input logic [31:0] src, input logic [31:0] dst, input int size,
                         input logic role, input int cmd_stall, input int rsp_stall,
                         input int err_beat, input bit poke);
    int          nstr0;
    int          beats;
    logic [31:0] rd;
    logic [31:0] a_exp;
    logic [31:0] exp_status;
    bit          is_err;
    nstr0 = n_strobes;
    cfg_src_addr = src;
    cfg_dst_addr = dst;
    cfg_size     = 16'(size);
    cfg_role     = role;
    cfg_start    = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check_val("busy_rise", status[0], 64'd1);
    for (int i = 0; i <= size; i++) begin
      a_exp = src + 32'(4 * i);
      wait_cmd();
      check_val("cmd_addr", u_if.m_icb_cmd_addr, a_exp);
      for (int s = 0; s < cmd_stall; s++) begin
        if (poke && i == 0 && s == 0) begin
          cfg_src_addr = 32'hDEAD_0000;
          cfg_dst_addr = 32'h0000_1234;
          cfg_size     = 16'd9;
          cfg_role     = ~role;
          cfg_start    = 1'b1;
        end
        @(negedge clk);
        cfg_start = 1'b0;
        check_val("cmd_hold", {u_if.m_icb_cmd_valid, u_if.m_icb_cmd_addr}, {1'b1, a_exp});
      end
      u_if.m_icb_cmd_ready = 1'b1;
      @(negedge clk);
      u_if.m_icb_cmd_ready = 1'b0;
      for (int s = 0; s < rsp_stall; s++) begin
        @(negedge clk);
        check_val("rsp_ready", u_if.m_icb_rsp_ready, 64'd1);
      end
      rd     = $urandom;
      is_err = (i == err_beat);
      u_if.m_icb_rsp_valid = 1'b1;
      u_if.m_icb_rsp_rdata = rd;
      u_if.m_icb_rsp_err   = is_err;
      if (!(ABORT && is_err)) exp_q.push_back('{role, 15'(dst + 32'(i)), rd});
      @(negedge clk);
      u_if.m_icb_rsp_valid = 1'b0;
      u_if.m_icb_rsp_err   = 1'b0;
      if (ABORT && is_err) break;
    end
    for (int t = 0; t < 100 && !dma_done; t++) @(negedge clk);
    check_val("done_pulse", dma_done, 64'd1);
    @(negedge clk);
    check_val("done_one_cycle", dma_done, 64'd0);
    beats = (ABORT && err_beat >= 0 && err_beat <= size) ? err_beat : size + 1;
    exp_status = {16'(beats), 13'd0, (err_beat >= 0 && err_beat <= size), 1'b1, 1'b0};
    check_val("status", status, exp_status);
    check_val("strobe_count", 64'(n_strobes - nstr0), 64'(beats));
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    u_if.m_icb_cmd_ready = 1'b0;
    u_if.m_icb_rsp_valid = 1'b0;
    u_if.m_icb_rsp_err   = 1'b0;
    u_if.m_icb_rsp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst_status", status, 64'd0);
    check_val("rst_outs", {u_if.m_icb_cmd_valid, u_if.m_icb_rsp_ready, u_if.mvu_wr_data_en,
                           u_if.mvu_wr_weight_en, dma_done}, 64'd0);
    check_val("cmd_read", u_if.m_icb_cmd_read, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Reset while a read response is outstanding.
    cfg_src_addr = 32'h0000_0100;
    cfg_dst_addr = 32'd0;
    cfg_size     = 16'd3;
    cfg_role     = 1'b0;
    cfg_start    = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_cmd();
    u_if.m_icb_cmd_ready = 1'b1;
    @(negedge clk);
    u_if.m_icb_cmd_ready = 1'b0;
    check_val("pre_rst_rsp_ready", u_if.m_icb_rsp_ready, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_status", status, 64'd0);
    check_val("mid_rst_outs", {u_if.m_icb_cmd_valid, u_if.m_icb_rsp_ready, u_if.mvu_wr_data_en,
                               u_if.mvu_wr_weight_en, dma_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_idle", {u_if.m_icb_cmd_valid, status}, 64'd0);

    do_xfer(32'h8000_0000, 32'h0000_0010, 3, 1'b0, 0, 0, -1, 1'b0);
    do_xfer(32'h0000_2000, 32'h0000_0040, 0, 1'b1, 5, 5, -1, 1'b0);
    do_xfer(32'hFFFF_FFFC, 32'h0000_7FFF, 1, 1'b0, 0, 0, -1, 1'b0);
    do_xfer(32'h0000_3000, 32'h0000_0100, 2, 1'b1, 2, 1, -1, 1'b1);
    do_xfer(32'h0000_4000, 32'h0000_0200, 3, 1'b0, 0, 0, 1, 1'b0);
    do_xfer(32'h0000_5000, 32'h0000_0300, 1, 1'b0, 1, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
